// File: rtl/lsu_subword_if.sv
// rtl/lsu_subword_if.sv - datapath request/response and data-memory bus bundle for lsu_subword
interface lsu_subword_if #(
  parameter int ADDR_W = 10
);
  // datapath request side
  logic              req;
  logic              st;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  // datapath response side
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  // word-wide data memory side
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;

  // environment view: drives requests and plays the data memory
  modport master (
    output req, st, size, sext, addr, wdata, dm_dout,
    input  busy, done, err, rdata, dm_addr, dm_din, dm_we
  );

  // load/store unit view
  modport slave (
    input  req, st, size, sext, addr, wdata, dm_dout,
    output busy, done, err, rdata, dm_addr, dm_din, dm_we
  );
endinterface

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module lsu_subword #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_subword_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MRG  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q;
  state_t            state_d;

  // latched request
  logic              st_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // merged word for sub-word stores, registered outputs
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              err_q;

  // combinational helpers
  logic              accept;
  logic              misalign;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  assign accept = (state_q == IDLE) && bus.req;

  // A request is trapped when its size is illegal or its address is not naturally aligned
  always_comb begin
    misalign = 1'b0;
    case (bus.size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = bus.addr[0];
      SZ_WORD: misalign = (bus.addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: loads read once, word stores write once, sub-word stores merge then write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req && !misalign) begin
          if (!bus.st) begin
            state_d = RD;
          end else if (bus.size == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = MRG;
          end
        end
      end
      RD:      state_d = IDLE;
      MRG:     state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane selection from the addressed word
  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.dm_dout[7:0];
      2'd1:    byte_lane = bus.dm_dout[15:8];
      2'd2:    byte_lane = bus.dm_dout[23:16];
      default: byte_lane = bus.dm_dout[31:24];
    endcase
    half_lane = addr_q[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
  end

  // Sign/zero extension of the selected lane; a full word passes through unchanged
  always_comb begin
    load_val = bus.dm_dout;
    case (size_q)
      SZ_BYTE: load_val = sext_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h000000, byte_lane};
      SZ_HALF: load_val = sext_q ? {{16{half_lane[15]}}, half_lane} : {16'h0000, half_lane};
      default: load_val = bus.dm_dout;
    endcase
  end

  // Replace only the addressed lane of the current word, keeping the other lanes intact
  always_comb begin
    merge_val = bus.dm_dout;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) begin
        merge_val[31:16] = wdata_q[15:0];
      end else begin
        merge_val[15:0]  = wdata_q[15:0];
      end
    end
  end

  // Request capture, load result, merge buffer and the one-cycle done/err pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        st_q    <= bus.st;
        size_q  <= bus.size;
        sext_q  <= bus.sext;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        if (misalign) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
      case (state_q)
        RD: begin
          rdata_q <= load_val;
          done_q  <= 1'b1;
        end
        MRG: merge_q <= merge_val;
        WR:  done_q  <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
  // Word stores write the latched data directly; sub-word stores write the merged word
  assign bus.dm_din  = (size_q == SZ_WORD) ? wdata_q : merge_q;
  // Gated by rst_n so that a reset cycle can never commit a write
  assign bus.dm_we   = (state_q == WR) && st_q && rst_n;

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - table-driven scoreboard bench for lsu_subword
module tb_lsu_subword;

  localparam int ADDR_W = 10;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    int          issue_cyc;
    int          we_at;
    logic [9:0]  addr;
  } sb_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   we_cnt;
  int   n_cmp;
  int   n_fail;

  logic [31:0] mem [0:255];
  vec_t        vecs [$];
  sb_t         sbq  [$];

  lsu_subword_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_subword #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word-wide data memory model with combinational read
  assign bus.dm_dout = mem[bus.dm_addr[9:2]];
  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr[9:2]] <= bus.dm_din;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dm_we) we_cnt <= we_cnt + 1;
  end

  function automatic vec_t mk(input logic st, input logic [1:0] size, input logic sext,
                              input logic [9:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.st = st; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // drop any previous request, wait for idle, then present one request for one cycle
  task automatic issue(input vec_t v, input int idx);
    sb_t e;
    int  t;
    @(negedge clk);
    bus.req = 1'b0;
    t = 0;
    while (bus.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("issue_timeout", 32'(t), 32'd0);
    bus.req   = 1'b1;
    bus.st    = v.st;
    bus.size  = v.size;
    bus.sext  = v.sext;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    e.idx       = idx;
    e.rdata     = v.exp_rdata;
    e.err       = v.exp_err;
    e.lat       = v.exp_lat;
    e.we        = (v.st && !v.exp_err) ? 1 : 0;
    e.issue_cyc = cyc;
    e.we_at     = we_cnt;
    e.addr      = v.addr;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int t;
    @(negedge clk);
    bus.req = 1'b0;
    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    sb_t  e;
    int   we_snap;
    vec_t v;

    cyc = 0; we_cnt = 0; n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    rst_n = 1'b0;
    bus.req = 1'b0; bus.st = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = '0; bus.wdata = 32'h0;

    // st, size, sext, addr, wdata, expected rdata after completion, err, latency
    vecs.push_back(mk(1, 2'b10, 0, 10'h004, 32'h11223344, 32'h00000000, 0, 2));
    vecs.push_back(mk(0, 2'b10, 0, 10'h004, 32'h0,        32'h11223344, 0, 2));
    vecs.push_back(mk(1, 2'b00, 0, 10'h005, 32'h000000AA, 32'h11223344, 0, 3));
    vecs.push_back(mk(0, 2'b00, 1, 10'h005, 32'h0,        32'hFFFFFFAA, 0, 2));
    vecs.push_back(mk(0, 2'b00, 0, 10'h005, 32'h0,        32'h000000AA, 0, 2));
    vecs.push_back(mk(1, 2'b01, 0, 10'h006, 32'h00008001, 32'h000000AA, 0, 3));
    vecs.push_back(mk(0, 2'b01, 1, 10'h006, 32'h0,        32'hFFFF8001, 0, 2));
    vecs.push_back(mk(0, 2'b01, 0, 10'h006, 32'h0,        32'h00008001, 0, 2));
    vecs.push_back(mk(0, 2'b00, 1, 10'h004, 32'h0,        32'h00000044, 0, 2));
    vecs.push_back(mk(0, 2'b10, 0, 10'h006, 32'h0,        32'h00000044, 1, 1));
    vecs.push_back(mk(1, 2'b01, 0, 10'h003, 32'h1234,     32'h00000044, 1, 1));
    vecs.push_back(mk(0, 2'b11, 0, 10'h004, 32'h0,        32'h00000044, 1, 1));
    vecs.push_back(mk(1, 2'b11, 0, 10'h008, 32'hFFFFFFFF, 32'h00000044, 1, 1));
    vecs.push_back(mk(0, 2'b10, 1, 10'h004, 32'h0,        32'h8001AA44, 0, 2));
    vecs.push_back(mk(0, 2'b00, 1, 10'h007, 32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk(0, 2'b00, 0, 10'h006, 32'h0,        32'h00000001, 0, 2));
    vecs.push_back(mk(0, 2'b01, 1, 10'h004, 32'h0,        32'hFFFFAA44, 0, 2));
    vecs.push_back(mk(1, 2'b10, 0, 10'h00C, 32'hDEADBEEF, 32'hFFFFAA44, 0, 2));
    vecs.push_back(mk(1, 2'b00, 0, 10'h00F, 32'h00000012, 32'hFFFFAA44, 0, 3));
    vecs.push_back(mk(1, 2'b01, 0, 10'h00C, 32'hFFFF5678, 32'hFFFFAA44, 0, 3));
    vecs.push_back(mk(0, 2'b10, 0, 10'h00C, 32'h0,        32'h12AD5678, 0, 2));
    vecs.push_back(mk(0, 2'b01, 0, 10'h00E, 32'h0,        32'h000012AD, 0, 2));
    vecs.push_back(mk(0, 2'b00, 1, 10'h00D, 32'h0,        32'h00000056, 0, 2));
    vecs.push_back(mk(1, 2'b00, 0, 10'h00C, 32'hFFFFFF7F, 32'h00000056, 0, 3));
    vecs.push_back(mk(0, 2'b10, 0, 10'h00C, 32'h0,        32'h12AD567F, 0, 2));
    vecs.push_back(mk(0, 2'b01, 1, 10'h005, 32'h0,        32'h12AD567F, 1, 1));

    fork
      // scoreboard monitor: pops one expectation per done pulse
      forever begin
        @(negedge clk);
        if (rst_n && bus.done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk($sformatf("op%0d_rdata", e.idx), bus.rdata, e.rdata);
            chk($sformatf("op%0d_err", e.idx), 32'(bus.err), 32'(e.err));
            chk($sformatf("op%0d_latency", e.idx), 32'(cyc - e.issue_cyc), 32'(e.lat));
            chk($sformatf("op%0d_we_cycles", e.idx), 32'(we_cnt - e.we_at), 32'(e.we));
            if (e.err) chk($sformatf("op%0d_busy_on_err", e.idx), 32'(bus.busy), 32'd0);
          end
        end
        if (rst_n && bus.busy && sbq.size() != 0) begin
          chk("dm_addr_stable", 32'(bus.dm_addr), 32'({sbq[$].addr[9:2], 2'b00}));
        end
        if (bus.dm_we) chk("dm_we_aligned", 32'(bus.dm_addr[1:0]), 32'd0);
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_done",  32'(bus.done),  32'd0);
    chk("reset_err",   32'(bus.err),   32'd0);
    chk("reset_rdata", bus.rdata,      32'h0);
    chk("reset_dm_we", 32'(bus.dm_we), 32'd0);
    rst_n = 1'b1;

    // table: each op issues as soon as the unit is idle, which lands in the previous done cycle
    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], i);
    drain();
    chk("mem_word_004", mem[1], 32'h8001AA44);
    chk("mem_word_00C", mem[3], 32'h12AD567F);
    chk("mem_word_008", mem[2], 32'hA5000002);

    // req pulsed while busy must be ignored
    issue(mk(0, 2'b10, 0, 10'h00C, 32'h0, 32'h12AD567F, 0, 2), 100);
    @(negedge clk);
    chk("busy_during_load", 32'(bus.busy), 32'd1);
    bus.st = 1'b1; bus.size = 2'b10; bus.addr = 10'h010; bus.wdata = 32'h0BADBAD0;
    @(negedge clk);
    bus.req = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("ignored_req_mem", mem[4], 32'hA5000004);
    chk("ignored_req_busy", 32'(bus.busy), 32'd0);

    // reset in the merge cycle of SB 0x008 abandons it
    @(negedge clk);
    we_snap = we_cnt;
    bus.req = 1'b1; bus.st = 1'b1; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = 10'h008; bus.wdata = 32'h000000AA;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rst_seq_busy_mrg", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_seq_busy_after", 32'(bus.busy), 32'd0);
    chk("rst_seq_rdata", bus.rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_seq_no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    chk("rst_seq_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("rst_seq_mem", mem[2], 32'hA5000002);

    // unit works normally after the abandoned operation
    issue(mk(0, 2'b10, 0, 10'h008, 32'h0, 32'hA5000002, 0, 2), 200);
    issue(mk(0, 2'b00, 0, 10'h00B, 32'h0, 32'h000000A5, 0, 2), 201);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
